// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the RV32I cores: opcodes, multicycle FSM states
// and the datapath mux / ALUOp / immediate-format select values.
package riscv_ctrl_pkg;

  // Opcodes understood by the controllers
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Multicycle FSM states; encodings are visible on the debug state port
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // Result mux select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALUOp handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate formats
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // True for any opcode the multicycle core can execute
  function automatic logic isSupported(input logic [6:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
           (opcode == OP_IALU) || (opcode == OP_BEQ) || (opcode == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_controller_imm_src_decoder.sv
// Opcode to immediate-format map, shared between the single-cycle and
// multicycle cores. Anything without its own format falls back to I-type.
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [1:0] imm_src_o
);

  // Pure combinational lookup on the opcode
  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_SW:   imm_src_o = IMM_S;
      OP_BEQ:  imm_src_o = IMM_B;
      OP_JAL:  imm_src_o = IMM_J;
      default: imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM. Sequences the shared memory/ALU datapath
// through fetch, decode, execute, memory and writeback, stalling on mem_ready.
// Outputs are Moore-style from the state, with FETCH gated by mem_ready and
// BEQ gated by zero; reset forces every write enable low immediately.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   pcUpdate;
  logic   branch;

  imm_src_decoder u_imm_src_decoder (
    .op_i      (op),
    .imm_src_o (ImmSrc)
  );

  assign state = state_q;

  // State register; reset abandons whatever instruction is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: memory states hold until mem_ready, others advance
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_IALU:      state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_MEMWB:    state_d = S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode per state, then reset override to FETCH selects with no writes
  always_comb begin
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    illegal   = 1'b0;
    pcUpdate  = 1'b0;
    branch    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        pcUpdate  = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        illegal = ~isSupported(op);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pcUpdate = 1'b1;
        RegWrite = 1'b1;
      end
      default: begin
        AdrSrc = 1'b0;
      end
    endcase
    PCWrite = pcUpdate | (branch & zero);
    if (rst) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      illegal   = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = RES_ALURESULT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_FOUR;
      ALUOp     = ALUOP_ADD;
    end
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle variant of the RV32I core. Per cycle, it sequences a shared datapath: a single unified memory, a single ALU, and the IR, PC and register file. It steps each instruction through fetch, decode, execute, memory and writeback states, and it stalls on a memory-ready handshake. It drives all datapath mux selects and write enables. The existing ALU decoder consumes its `ALUOp`.

## Interface
- No parameters.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `op` input 7: opcode field from the IR, meaningful from DECODE onward.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: unified memory has completed the current access.
- `PCWrite` output 1: PC register enable.
- `AdrSrc` output 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemWrite` output 1: memory write strobe.
- `IRWrite` output 1: IR and OldPC capture enable.
- `RegWrite` output 1: register file write enable.
- `ResultSrc` output 2: result mux select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` output 2: ALU operand A select. 00 = PC, 01 = OldPC, 10 = rs1 register.
- `ALUSrcB` output 2: ALU operand B select. 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `ALUOp` output 2: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- `ImmSrc` output 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `illegal` output 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `state` output 4: current state encoding, for debug and verification.

## Operation
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10.
- Transitions:
  - FETCH → DECODE when `mem_ready`, otherwise hold.
  - DECODE → MEMADR for lw/sw, EXECUTER for R-type, EXECUTEI for I-ALU, BEQ for beq, JAL for jal.
  - DECODE → FETCH for any other opcode, with `illegal`=1.
  - MEMADR → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD → MEMWB when `mem_ready`, otherwise hold.
  - MEMWRITE → FETCH when `mem_ready`, otherwise hold.
  - EXECUTER and EXECUTEI → ALUWB.
  - MEMWB, ALUWB, BEQ and JAL → FETCH.
  - Unused encodings 11–15 → FETCH.
- Outputs are Moore-style from `state`, with the gating listed below. Any signal not listed for a state is 0.
  - FETCH: `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10, `IRWrite`=`mem_ready`, PC update=`mem_ready`.
  - DECODE: `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00. This precomputes the branch/jump target.
  - MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00.
  - MEMREAD: `AdrSrc`=1, `ResultSrc`=00.
  - MEMWB: `ResultSrc`=01, `RegWrite`=1.
  - MEMWRITE: `AdrSrc`=1, `ResultSrc`=00, `MemWrite`=1, held for the whole state.
  - EXECUTER: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10.
  - EXECUTEI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10.
  - ALUWB: `ResultSrc`=00, `RegWrite`=1.
  - BEQ: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00, branch=1.
  - JAL: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, PC update=1, `RegWrite`=1.
- `PCWrite` = PC update | (branch & `zero`).
- `ImmSrc` is purely combinational from `op`: sw → 01, beq → 10, jal → 11, everything else → 00.

## Timing
- State register updates on the rising edge of `clk`.
- If `rst`=1 at an edge, the next state is FETCH, whatever the current state.
- While `rst`=1:
  - `PCWrite`, `IRWrite`, `MemWrite`, `RegWrite` and `illegal` are forced to 0.
  - Mux selects show their FETCH values.
  - `state` reads 0 from the first edge after `rst` is asserted.
- Reset asserted mid-instruction abandons the instruction. No write enable fires in the reset cycle.
- Cycles per instruction with `mem_ready` held at 1:
  - lw: 5.
  - sw, R-type, I-ALU: 4.
  - beq, jal: 3.
  - Illegal opcode: 2.
- Each cycle `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- During a stall every output is held stable. In FETCH, `IRWrite` and `PCWrite` stay 0 until the ready cycle, so the PC advances exactly once per fetch.
- `MemWrite` stays asserted through a stalled MEMWRITE. The memory must commit the write once, in the `mem_ready` cycle.
- `zero` is sampled combinationally in BEQ only.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - the opcode constants;
  - the state enum (4-bit, encodings as above);
  - the `ResultSrc`, `ALUSrcA`, `ALUSrcB`, `ALUOp` and `ImmSrc` encodings, which the datapath and ALU decoder also use.
- One sub-module is natural: `imm_src_decoder`, the combinational `op` → `ImmSrc` map, shareable with the single-cycle core.
- The state register, next-state logic and output logic stay in this module.

## Test plan
- Reset, then `op`=0110011 with `mem_ready`=1 → `state` sequence 0,1,6,8,0. `IRWrite`=1 and `PCWrite`=1 in cycle 1 only. `RegWrite`=1 in the ALUWB cycle only.
- lw (0000011) with `mem_ready`=0 for 2 cycles in FETCH and 3 cycles in MEMREAD → sequence 0,0,0,1,2,3,3,3,3,4,0. `PCWrite` pulses once. `AdrSrc`=1 throughout MEMREAD.
- sw (0100011) with `mem_ready`=0 for 1 cycle in MEMWRITE → `MemWrite`=1 for 2 consecutive cycles, `ImmSrc`=01, then FETCH.
- beq (1100011) twice, first with `zero`=1, then with `zero`=0 → `PCWrite`=1 in BEQ the first time and 0 the second time. `ALUOp`=01 both times. `ImmSrc`=10.
- jal (1101111) → sequence 0,1,10,0. `PCWrite`=1 and `RegWrite`=1 in JAL. `ImmSrc`=11.
- `op`=0000000 → `illegal` pulses in DECODE and the next state is FETCH. Separately, assert `rst` in the EXECUTEI cycle → `RegWrite` never asserts and `state`=0 on the next cycle.
